// File: rtl/regfile_2w2r.sv
// regfile_2w2r
//   Parametrised register file for the processor datapath, sitting between
//   decode/issue and ALU/writeback. It has two synchronous read ports with
//   write-first bypass, two write ports where port B has priority, a per-register
//   busy scoreboard for issue-time hazard detection, and an optional hardwired-zero
//   register 0.
//
// Parameters
//   WIDTH    data width of each register
//   DEPTH    number of registers (power of two, >= 2)
//   AW       address width, derived from DEPTH; do not override
//   ZERO_REG 1 = register 0 reads as 0 and ignores writes and reservations
//
// Ports
//   CLK            clock; all state updates on the rising edge
//   RESET_N        synchronous reset, active-low
//   RD_EN, SA, SB  read request and the two read addresses
//   DataA, DataB   registered read data (valid when RD_VALID=1, held otherwise)
//   BUSY_A, BUSY_B registered scoreboard bit of SA / SB at read time
//   RD_VALID       one-cycle pulse following each accepted read
//   LD_A, DR_A, D_IN_A  write port A (primary writeback)
//   LD_B, DR_B, D_IN_B  write port B (secondary writeback, wins collisions)
//   RSV, RSV_DR    reserve: mark RSV_DR busy (newer pending write)
//   BUSY_VEC       current scoreboard, bit i = register i busy

module regfile_2w2r #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AW       = $clog2(DEPTH),
   parameter int unsigned ZERO_REG = 0
) (
   input  logic             CLK,
   input  logic             RESET_N,
   // read side
   input  logic             RD_EN,
   input  logic [AW-1:0]    SA,
   input  logic [AW-1:0]    SB,
   output logic [WIDTH-1:0] DataA,
   output logic [WIDTH-1:0] DataB,
   output logic             BUSY_A,
   output logic             BUSY_B,
   output logic             RD_VALID,
   // write port A
   input  logic             LD_A,
   input  logic [AW-1:0]    DR_A,
   input  logic [WIDTH-1:0] D_IN_A,
   // write port B
   input  logic             LD_B,
   input  logic [AW-1:0]    DR_B,
   input  logic [WIDTH-1:0] D_IN_B,
   // scoreboard
   input  logic             RSV,
   input  logic [AW-1:0]    RSV_DR,
   output logic [DEPTH-1:0] BUSY_VEC
);

   localparam bit HAS_ZERO = (ZERO_REG != 0);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // one-hot per-register request decode
   logic [DEPTH-1:0] hit_a;
   logic [DEPTH-1:0] hit_b;
   logic [DEPTH-1:0] hit_rsv;

   always_comb begin : decode
      hit_a   = '0;
      hit_b   = '0;
      hit_rsv = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         hit_a[i]   = LD_A && (DR_A   == AW'(i));
         hit_b[i]   = LD_B && (DR_B   == AW'(i));
         hit_rsv[i] = RSV  && (RSV_DR == AW'(i));
      end
      // hardwired zero: register 0 is invisible to every request
      if (HAS_ZERO) begin
         hit_a[0]   = 1'b0;
         hit_b[0]   = 1'b0;
         hit_rsv[0] = 1'b0;
      end
   end

   // Next state of every register doubles as the write-first bypass source:
   // reading regs_d/busy_d at SA/SB yields exactly what the array will hold
   // after this edge, so the read path needs no separate forwarding compare.
   always_comb begin : next_state
      busy_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         regs_d[i] = hit_b[i] ? D_IN_B : (hit_a[i] ? D_IN_A : regs_q[i]);
         // a reservation in the same cycle is a newer pending write, so it
         // overrides the clear from a completing write
         busy_d[i] = hit_rsv[i] | (busy_q[i] & ~(hit_a[i] | hit_b[i]));
      end
      if (HAS_ZERO) begin
         regs_d[0] = '0;
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q   <= '0;
         DataA    <= '0;
         DataB    <= '0;
         BUSY_A   <= 1'b0;
         BUSY_B   <= 1'b0;
         RD_VALID <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
         busy_q   <= busy_d;
         RD_VALID <= RD_EN;
         if (RD_EN) begin
            DataA  <= regs_d[SA];
            DataB  <= regs_d[SB];
            BUSY_A <= busy_d[SA];
            BUSY_B <= busy_d[SB];
         end
      end
   end

   assign BUSY_VEC = busy_q;

endmodule
